// File: rtl/reg_display_ctrl_pkg.sv
// Shared types, segment constants and the hex-to-segment decode used by the
// register display controller.
package riscv_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    SHOW = 2'd3
  } disp_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Segment order is {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/reg_display_ctrl_if.sv
// Debug read port between the display controller (master) and the register file (slave).
interface reg_display_ctrl_if;
  // Handshake: master raises dbg_req with dbg_addr and holds both stable until the
  // slave answers with a single-cycle dbg_ack carrying dbg_data in that same cycle;
  // dbg_req drops on the edge that samples the ack (or when the master gives up).
  logic [4:0]  dbg_addr;
  logic        dbg_req;
  logic        dbg_ack;
  logic [31:0] dbg_data;

  modport master (output dbg_addr, output dbg_req, input dbg_ack, input dbg_data);
  modport slave  (input dbg_addr, input dbg_req, output dbg_ack, output dbg_data);
endinterface

// File: rtl/reg_display_ctrl_seg7_encoder.sv
// One seven-segment digit: hex decode with a forced-blank override.
module seg7_encoder
  import riscv_dbg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);
  assign seg = blank ? SEG_BLANK : hex_to_seg7(nibble);
endmodule

// File: rtl/reg_display_ctrl.sv
// Debounces the register-select switches, fetches the selected register over the
// debug read port, and shows it on six seven-segment digits with periodic refresh.
module reg_display_ctrl
  import riscv_dbg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REFRESH_CYCLES  = 1000000,
  parameter int ACK_TIMEOUT     = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          SW,
  input  logic                page_sel,
  reg_display_ctrl_if.master  dbg,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2,
  output logic [6:0]          HEX3,
  output logic [6:0]          HEX4,
  output logic [6:0]          HEX5,
  output logic                rd_err,
  output disp_state_t         fsm_state
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RF_W = $clog2(REFRESH_CYCLES + 1);
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic [4:0]      sw_s1, sw_s2, sw_cand, sel_q;
  logic            page_s1, page_s2, page_cand, page_q;
  logic [DB_W-1:0] sw_cnt, page_cnt;
  logic            sel_commit, page_commit;
  logic [4:0]      sel_next;

  logic [RF_W-1:0] refresh_timer;
  logic [TO_W-1:0] wait_cnt;
  logic [31:0]     cap_val, shown_val, disp_src;
  logic [6:0]      seg_d [6];
  logic            stale;

  // A commit rewrites sel_q with the same candidate while it stays stable.
  assign sel_commit  = (sw_s2 == sw_cand) && (sw_cnt == DB_LAST);
  assign page_commit = (page_s2 == page_cand) && (page_cnt == DB_LAST);
  assign sel_next    = sel_commit ? sw_cand : sel_q;
  assign stale       = (sel_q != dbg.dbg_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      sw_cand   <= '0;
      sw_cnt    <= '0;
      sel_q     <= '0;
      page_s1   <= 1'b0;
      page_s2   <= 1'b0;
      page_cand <= 1'b0;
      page_cnt  <= '0;
      page_q    <= 1'b0;
    end else begin
      sw_s1   <= SW;
      sw_s2   <= sw_s1;
      page_s1 <= page_sel;
      page_s2 <= page_s1;
      if (sw_s2 != sw_cand) begin
        sw_cand <= sw_s2;
        sw_cnt  <= '0;
      end else if (sw_cnt != DB_LAST) begin
        sw_cnt <= sw_cnt + DB_W'(1);
      end
      if (sel_commit) sel_q <= sw_cand;
      if (page_s2 != page_cand) begin
        page_cand <= page_s2;
        page_cnt  <= '0;
      end else if (page_cnt != DB_LAST) begin
        page_cnt <= page_cnt + DB_W'(1);
      end
      if (page_commit) page_q <= page_cand;
    end
  end

  // In SHOW the freshly captured value drives the digits, so HEX lands on that edge.
  assign disp_src = (fsm_state == SHOW) ? cap_val : shown_val;

  for (genvar k = 0; k < 6; k++) begin : g_dig
    logic [3:0] nib;
    if (k < 2) begin : g_lo
      assign nib = page_q ? disp_src[24 + 4*k +: 4] : disp_src[4*k +: 4];
    end else begin : g_hi
      assign nib = disp_src[4*k +: 4];
    end
    seg7_encoder u_enc (
      .nibble (nib),
      .blank  ((k >= 2) ? page_q : 1'b0),
      .seg    (seg_d[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_state     <= IDLE;
      dbg.dbg_req   <= 1'b0;
      dbg.dbg_addr  <= '0;
      rd_err        <= 1'b0;
      cap_val       <= '0;
      shown_val     <= '0;
      refresh_timer <= '0;
      wait_cnt      <= '0;
      HEX0 <= SEG_ZERO;
      HEX1 <= SEG_ZERO;
      HEX2 <= SEG_ZERO;
      HEX3 <= SEG_ZERO;
      HEX4 <= SEG_ZERO;
      HEX5 <= SEG_ZERO;
    end else begin
      HEX0 <= seg_d[0];
      HEX1 <= seg_d[1];
      HEX2 <= seg_d[2];
      HEX3 <= seg_d[3];
      HEX4 <= seg_d[4];
      HEX5 <= seg_d[5];
      case (fsm_state)
        IDLE: begin
          if ((sel_next != dbg.dbg_addr) || (refresh_timer == RF_LAST)) begin
            refresh_timer <= '0;
            fsm_state     <= REQ;
          end else begin
            refresh_timer <= refresh_timer + RF_W'(1);
          end
        end
        REQ: begin
          dbg.dbg_addr <= sel_q;
          dbg.dbg_req  <= 1'b1;
          wait_cnt     <= '0;
          fsm_state    <= WAIT;
        end
        WAIT: begin
          // A selection that moved mid-read throws the result away and re-reads.
          if (dbg.dbg_ack) begin
            dbg.dbg_req <= 1'b0;
            if (stale) begin
              fsm_state <= REQ;
            end else begin
              cap_val   <= dbg.dbg_data;
              rd_err    <= 1'b0;
              fsm_state <= SHOW;
            end
          end else if (wait_cnt == TO_LAST) begin
            dbg.dbg_req <= 1'b0;
            if (stale) begin
              fsm_state <= REQ;
            end else begin
              cap_val   <= 32'hEEEEEEEE;
              rd_err    <= 1'b1;
              fsm_state <= SHOW;
            end
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        SHOW: begin
          shown_val <= cap_val;
          fsm_state <= IDLE;
        end
        default: fsm_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_display_ctrl.sv
// Scoreboard bench for reg_display_ctrl: register-file responder, display model,
// monitor that pops expected digit patterns whenever the HEX outputs change.
module tb_reg_display_ctrl;
  import riscv_dbg_pkg::*;

  localparam int DB     = 4;
  localparam int RF     = 16;
  localparam int TO     = 15;
  localparam int NO_ACK = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  sw = '0;
  logic        page_sel = 1'b0;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        rd_err;
  disp_state_t fsm_state;

  reg_display_ctrl_if bus ();

  reg_display_ctrl #(.DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .SW(sw), .page_sel(page_sel), .dbg(bus),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
    .rd_err(rd_err), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- shared state ----------------
  int          total = 0;
  int          bad = 0;
  logic [41:0] exp_q[$];
  logic [41:0] model_disp, hex_prev;
  logic [6:0]  seg_tab[16];
  logic [31:0] regs[32];
  int          ack_delay = 0;
  logic [4:0]  sel_cur = '0, sel_prev = '0;
  logic        cur_page = 1'b0;
  int          cyc = 0, req_count = 0, req_rise_cyc = 0, req_gap = 0;
  int          req_len = 0, last_req_len = 0, hex_chg_cyc = 0;
  logic [4:0]  last_req_addr = '0;
  logic        req_prev = 1'b0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Six digits per the segment table; page 1 shows the top byte with 4 blank digits.
  function automatic logic [41:0] disp_of(input logic [31:0] v, input logic pg);
    logic [41:0] d;
    logic [31:0] s;
    s = pg ? (v >> 24) : v;
    for (int k = 0; k < 6; k++)
      d[7*k +: 7] = (pg && k >= 2) ? 7'h7F : seg_tab[s[4*k +: 4]];
    return d;
  endfunction

  function automatic logic [41:0] hex_now();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_disp(input logic [31:0] v, input logic pg);
    logic [41:0] d;
    d = disp_of(v, pg);
    if (d != model_disp) begin
      exp_q.push_back(d);
      model_disp = d;
    end
  endtask

  task automatic set_sel(input logic [4:0] s);
    sel_prev = sel_cur;
    sel_cur  = s;
    sw       = s;
  endtask

  task automatic wait_req(input int max);
    int start;
    int n;
    start = req_count;
    n = 0;
    while (req_count == start && n < max) begin
      @(negedge clk);
      n++;
    end
    check("wait_req_seen", req_count != start, 1);
  endtask

  // ---------------- register-file responder ----------------
  initial begin : responder
    bit busy;
    int rcnt;
    busy = 0;
    rcnt = 0;
    bus.dbg_ack  = 1'b0;
    bus.dbg_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.dbg_ack = 1'b0;
      if (bus.dbg_req && !reset) begin
        if (!busy) begin
          busy = 1;
          rcnt = 0;
        end
        if (ack_delay != NO_ACK && rcnt >= ack_delay) begin
          bus.dbg_ack  = 1'b1;
          bus.dbg_data = regs[bus.dbg_addr];
          busy = 0;
        end else begin
          rcnt++;
        end
      end else begin
        busy = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (hex_now() !== hex_prev) begin
        hex_chg_cyc = cyc;
        if (exp_q.size() == 0) check("hex_unexpected", hex_now(), hex_prev);
        else check("hex_update", hex_now(), exp_q.pop_front());
        hex_prev = hex_now();
      end
      if (bus.dbg_req && !req_prev) begin
        req_count++;
        req_gap       = cyc - req_rise_cyc;
        req_rise_cyc  = cyc;
        last_req_addr = bus.dbg_addr;
        req_len       = 0;
        check("req_addr", (bus.dbg_addr == sel_cur) || (bus.dbg_addr == sel_prev), 1);
      end
      if (bus.dbg_req) begin
        req_len++;
        check("addr_stable", bus.dbg_addr, last_req_addr);
      end
      if (!bus.dbg_req && req_prev) last_req_len = req_len;
      req_prev = bus.dbg_req;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int start;
    logic [31:0] v;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0]  = 32'h0;
    regs[8]  = 32'h4;
    regs[9]  = 32'h1234560C;
    regs[20] = 32'hA;
    model_disp = disp_of(32'h0, 1'b0);
    hex_prev   = model_disp;

    reset = 1'b1;
    tick(3);
    check("rst_hex", hex_now(), {6{SEG_ZERO}});
    check("rst_req", bus.dbg_req, 0);
    check("rst_addr", bus.dbg_addr, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_state", fsm_state, IDLE);

    // Select x8 straight out of reset: one read, digits 000004 two cycles after req.
    set_sel(5'd8);
    expect_disp(regs[8], 1'b0);
    mon_en = 1'b1;
    reset  = 1'b0;
    start  = req_count;
    wait_req(20);
    tick(4);
    check("t1_latency", hex_chg_cyc - req_rise_cyc, 2);
    check("t1_addr", last_req_addr, 8);
    check("t1_one_req", req_count - start, 1);
    check("t1_rd_err", rd_err, 0);
    sel_prev = sel_cur;

    // Two-cycle glitch to 13 must neither commit nor trigger a read.
    wait_req(40);
    tick(3);
    sw = 5'd13;
    tick(2);
    sw = 5'd8;
    start = req_count;
    tick(10);
    check("glitch_no_req", req_count - start, 0);
    check("glitch_hex", hex_now(), model_disp);

    // x9 on page 0, then page 1 without any extra read, then back.
    set_sel(5'd9);
    expect_disp(regs[9], 1'b0);
    tick(30);
    sel_prev = sel_cur;
    check("x9_page0", hex_now(), disp_of(32'h1234560C, 1'b0));
    wait_req(40);
    page_sel = 1'b1;
    cur_page = 1'b1;
    expect_disp(regs[9], 1'b1);
    start = req_count;
    tick(14);
    check("page_no_req", req_count - start, 0);
    check("x9_page1", hex_now(), disp_of(32'h1234560C, 1'b1));
    page_sel = 1'b0;
    cur_page = 1'b0;
    expect_disp(regs[9], 1'b0);
    tick(20);

    // Silent responder: 15-cycle request, error flag, EEEEEE shown.
    ack_delay = NO_ACK;
    set_sel(5'd5);
    expect_disp(32'hEEEEEEEE, 1'b0);
    tick(60);
    sel_prev = sel_cur;
    check("to_req_len", last_req_len, TO);
    check("to_rd_err", rd_err, 1);
    check("to_hex", hex_now(), model_disp);
    ack_delay = 0;
    expect_disp(regs[5], 1'b0);
    tick(50);
    check("to_recover_err", rd_err, 0);

    // Selection moves to x20 mid-read: the x8 result must never reach the digits.
    set_sel(5'd8);
    expect_disp(regs[8], 1'b0);
    tick(30);
    sel_prev  = sel_cur;
    ack_delay = 10;
    wait_req(40);
    regs[8] = 32'h7;
    set_sel(5'd20);
    expect_disp(regs[20], 1'b0);
    tick(60);
    sel_prev = sel_cur;
    check("stale_addr", last_req_addr, 20);
    check("stale_hex", hex_now(), disp_of(32'hA, 1'b0));
    ack_delay = 0;

    // Register contents change between refreshes; refresh period is 16 idle + 3.
    regs[20] = $urandom;
    expect_disp(regs[20], 1'b0);
    tick(45);
    check("refresh_hex", hex_now(), model_disp);
    wait_req(40);
    wait_req(40);
    check("refresh_gap", req_gap, RF + 3);

    // Random mix of selection, page and register-content changes.
    for (int it = 0; it < 10; it++) begin
      ack_delay = $urandom_range(0, 4);
      case ($urandom_range(0, 2))
        0: set_sel(5'($urandom_range(0, 31)));
        1: begin
          cur_page = ~cur_page;
          page_sel = cur_page;
        end
        default: if (sel_cur != 5'd0) regs[sel_cur] = $urandom;
      endcase
      v = regs[sel_cur];
      expect_disp(v, cur_page);
      tick(45);
      sel_prev = sel_cur;
      check("rand_hex", hex_now(), model_disp);
      check("rand_rd_err", rd_err, 0);
    end

    // Reset while a read is outstanding.
    ack_delay = 8;
    wait_req(40);
    tick(2);
    check("pre_rst_in_wait", fsm_state, WAIT);
    reset = 1'b1;
    set_sel(5'd0);
    sel_prev = 5'd0;
    cur_page = 1'b0;
    page_sel = 1'b0;
    expect_disp(32'h0, 1'b0);
    tick(1);
    check("mid_rst_req", bus.dbg_req, 0);
    check("mid_rst_hex", hex_now(), {6{SEG_ZERO}});
    check("mid_rst_state", fsm_state, IDLE);
    tick(2);
    reset = 1'b0;
    ack_delay = 0;
    tick(40);
    check("post_rst_hex", hex_now(), {6{SEG_ZERO}});
    check("post_rst_err", rd_err, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
